// File: rtl/sap_pkg.sv
// Shared definitions for the SAP core: opcodes, microstep encoding and control-word bit positions.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // Control-word bit positions (mi: MAR in, ri/ro: RAM in/out, io: IR operand out, ...)
    localparam int unsigned CW_MI   = 0;
    localparam int unsigned CW_RI   = 1;
    localparam int unsigned CW_RO   = 2;
    localparam int unsigned CW_IO   = 3;
    localparam int unsigned CW_II   = 4;
    localparam int unsigned CW_AI   = 5;
    localparam int unsigned CW_AO   = 6;
    localparam int unsigned CW_SUMO = 7;
    localparam int unsigned CW_SUB  = 8;
    localparam int unsigned CW_BI   = 9;
    localparam int unsigned CW_OI   = 10;
    localparam int unsigned CW_CE   = 11;
    localparam int unsigned CW_CO   = 12;
    localparam int unsigned CW_J    = 13;
    localparam int unsigned CW_HLT  = 14;
    localparam int unsigned CW_W    = 15;

    typedef logic [CW_W-1:0] ctrl_t;

endpackage

// File: rtl/sap_ctrl.sv
// Microsequencer: step counter plus opcode/step/flags decode into the control word.
module sap_ctrl
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic [3:0] opcode,
    input  logic       carry,
    input  logic       zero,
    output ctrl_t      ctrl_c
);

    step_t step;
    step_t step_nx;

    always_comb begin
        ctrl_c  = '0;
        step_nx = T0;
        case (step)
            T0: begin
                ctrl_c[CW_CO] = 1'b1;
                ctrl_c[CW_MI] = 1'b1;
                step_nx       = T1;
            end
            T1: begin
                ctrl_c[CW_RO] = 1'b1;
                ctrl_c[CW_II] = 1'b1;
                ctrl_c[CW_CE] = 1'b1;
                step_nx       = T2;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_c[CW_IO] = 1'b1;
                        ctrl_c[CW_MI] = 1'b1;
                        step_nx       = T3;
                    end
                    OP_LDI: begin
                        ctrl_c[CW_IO] = 1'b1;
                        ctrl_c[CW_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_c[CW_IO] = 1'b1;
                        ctrl_c[CW_J]  = 1'b1;
                    end
                    OP_JC: begin
                        ctrl_c[CW_IO] = carry;
                        ctrl_c[CW_J]  = carry;
                    end
                    OP_JZ: begin
                        ctrl_c[CW_IO] = zero;
                        ctrl_c[CW_J]  = zero;
                    end
                    OP_OUT: begin
                        ctrl_c[CW_AO] = 1'b1;
                        ctrl_c[CW_OI] = 1'b1;
                    end
                    OP_HLT: ctrl_c[CW_HLT] = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl_c[CW_RO] = 1'b1;
                        ctrl_c[CW_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_c[CW_RO] = 1'b1;
                        ctrl_c[CW_BI] = 1'b1;
                        step_nx       = T4;
                    end
                    OP_STA: begin
                        ctrl_c[CW_RI] = 1'b1;
                        ctrl_c[CW_AO] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                ctrl_c[CW_SUMO] = 1'b1;
                ctrl_c[CW_AI]   = 1'b1;
                ctrl_c[CW_SUB]  = (opcode == OP_SUB);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= T0;
        end else if (adv) begin
            step <= step_nx;
        end
    end

endmodule

// File: rtl/sap_core.sv
// Parametrised SAP-style processor core with program-load port and single-step enable.
// Define SAP_CORE_FLAGS_EN to include the carry/zero flag register and conditional jumps.
module sap_core
    import sap_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              carry,
    output logic              zero,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] mar;
    logic [3:0]        ir_op;
    logic [ADDR_W-1:0] ir_arg;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] bus;
    ctrl_t             ctrl;
    logic              adv;

    assign adv = en & ~halted;

    sap_ctrl u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .adv    (adv),
        .opcode (ir_op),
        .carry  (carry),
        .zero   (zero),
        .ctrl_c (ctrl)
    );

    // MAR is registered, so the addressed word appears the step after MAR is loaded
    assign ram_q = mem[mar];

    // One-hot AND-OR bus; the sequencer never enables two drivers at once
    assign bus = ({DATA_W{ctrl[CW_CO]}}   & DATA_W'(pc))
               | ({DATA_W{ctrl[CW_RO]}}   & ram_q)
               | ({DATA_W{ctrl[CW_IO]}}   & DATA_W'(ir_arg))
               | ({DATA_W{ctrl[CW_AO]}}   & a)
               | ({DATA_W{ctrl[CW_SUMO]}} & alu);

`ifdef SAP_CORE_FLAGS_EN
    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, (ctrl[CW_SUB] ? ~b : b)} + (DATA_W+1)'(ctrl[CW_SUB]);
    assign alu = sum[DATA_W-1:0];

    // Only the ALU write-back step updates the flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (adv && ctrl[CW_SUMO]) begin
            carry <= sum[DATA_W];
            zero  <= (sum[DATA_W-1:0] == '0);
        end
    end
`else
    assign alu   = a + (ctrl[CW_SUB] ? ~b : b) + DATA_W'(ctrl[CW_SUB]);
    assign carry = 1'b0;
    assign zero  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            mar       <= '0;
            ir_op     <= '0;
            ir_arg    <= '0;
            a         <= '0;
            b         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= adv & ctrl[CW_OI];
            if (adv) begin
                if (ctrl[CW_MI]) mar <= bus[ADDR_W-1:0];
                if (ctrl[CW_II]) begin
                    ir_op  <= bus[DATA_W-1 -: 4];
                    ir_arg <= bus[ADDR_W-1:0];
                end
                if (ctrl[CW_AI]) a <= bus;
                if (ctrl[CW_BI]) b <= bus;
                if (ctrl[CW_OI]) out_data <= bus;
                if (ctrl[CW_J]) begin
                    pc <= bus[ADDR_W-1:0];
                end else if (ctrl[CW_CE]) begin
                    pc <= pc + ADDR_W'(1);
                end
                if (ctrl[CW_HLT]) halted <= 1'b1;
            end
        end
    end

    // RAM is not reset; program load only while the core is stopped, so it never races STA
    always_ff @(posedge clk) begin
        if (adv && ctrl[CW_RI]) begin
            mem[mar] <= a;
        end else if (prog_we && !adv) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_sap_core.sv
// Directed self-checking bench for sap_core; expectations follow SAP_CORE_FLAGS_EN when defined.
module tb_sap_core;

`ifdef SAP_CORE_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        halted;
    logic        carry;
    logic        zero;
    logic [3:0]  pc;

    logic        w_rst;
    logic        w_en;
    logic        w_we;
    logic [7:0]  w_addr;
    logic [11:0] w_data;
    logic [11:0] w_out;
    logic        w_valid;
    logic        w_halted;
    logic        w_carry;
    logic        w_zero;
    logic [7:0]  w_pc;

    int total;
    int passed;

    sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .carry     (carry),
        .zero      (zero),
        .pc        (pc)
    );

    sap_core #(.DATA_W(12), .ADDR_W(8)) dut_wide (
        .clk       (clk),
        .rst       (w_rst),
        .en        (w_en),
        .prog_we   (w_we),
        .prog_addr (w_addr),
        .prog_data (w_data),
        .out_data  (w_out),
        .out_valid (w_valid),
        .halted    (w_halted),
        .carry     (w_carry),
        .zero      (w_zero),
        .pc        (w_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] ad, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = ad;
        prog_data = d;
        tick(1);
        prog_we   = 1'b0;
    endtask

    task automatic wload(input logic [7:0] ad, input logic [11:0] d);
        w_we   = 1'b1;
        w_addr = ad;
        w_data = d;
        tick(1);
        w_we   = 1'b0;
    endtask

    task automatic restart();
        en  = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        total = 0; passed = 0;
        rst = 1'b0; en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        w_rst = 1'b0; w_en = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
        #1;
        rst = 1'b1; w_rst = 1'b1;
        #2;
        check("rst_pc",        32'(pc),        32'h0);
        check("rst_halted",    32'(halted),    32'h0);
        check("rst_carry",     32'(carry),     32'h0);
        check("rst_zero",      32'(zero),      32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0; w_rst = 1'b0;

        // LDA 14, ADD 15, OUT, HLT: 28 + 14
        load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
        load(4'd14, 8'h1C); load(4'd15, 8'h0E);
        en = 1'b1;
        tick(11); check("p1_valid_before", 32'(out_valid), 32'h0);
        tick(1);  check("p1_valid",        32'(out_valid), 32'h1);
                  check("p1_out",          32'(out_data),  32'h2A);
        tick(1);  check("p1_valid_pulse",  32'(out_valid), 32'h0);
        tick(1);  check("p1_halt_early",   32'(halted),    32'h0);
        tick(1);  check("p1_halted",       32'(halted),    32'h1);
                  check("p1_pc",           32'(pc),        32'h4);
                  check("p1_carry",        32'(carry),     32'h0);
                  check("p1_zero",         32'(zero),      32'h0);
        tick(3);  check("p1_halt_hold_pc", 32'(pc),        32'h4);

        // LDA 0xFF, ADD 1, JC 6; OUT at 6
        restart();
        load(4'd0, 8'h1D); load(4'd1, 8'h2E); load(4'd2, 8'h76); load(4'd3, 8'hF0);
        load(4'd6, 8'hE0); load(4'd7, 8'hF0); load(4'd13, 8'hFF); load(4'd14, 8'h01);
        en = 1'b1;
        tick(9);  check("p2_carry",  32'(carry),     32'(FL));
                  check("p2_zero",   32'(zero),      32'(FL));
        tick(3);  check("p2_jc_pc",  32'(pc),        FL ? 32'h6 : 32'h3);
        tick(3);  check("p2_valid",  32'(out_valid), 32'(FL));
                  check("p2_halted", 32'(halted),    32'(!FL));

        // LDI 3, SUB 5, JZ 9 (not taken), OUT
        restart();
        load(4'd0, 8'h53); load(4'd1, 8'h3F); load(4'd2, 8'h89); load(4'd3, 8'hE0);
        load(4'd4, 8'hF0); load(4'd15, 8'h05);
        en = 1'b1;
        tick(8);  check("p3_carry", 32'(carry),     32'h0);
                  check("p3_zero",  32'(zero),      32'h0);
        tick(3);  check("p3_jz_pc", 32'(pc),        32'h3);
        tick(3);  check("p3_valid", 32'(out_valid), 32'h1);
                  check("p3_out",   32'(out_data),  32'hFE);

        // Stall in ADD T3 and reload the B operand while stalled
        restart();
        load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
        load(4'd14, 8'h1C); load(4'd15, 8'h0E);
        en = 1'b1;
        tick(7);
        en = 1'b0;
        check("p4_pc_stall", 32'(pc), 32'h2);
        load(4'd15, 8'h20);
        tick(9);  check("p4_pc_hold",    32'(pc),        32'h2);
                  check("p4_valid_hold", 32'(out_valid), 32'h0);
                  check("p4_halt_hold",  32'(halted),    32'h0);
        en = 1'b1;
        tick(5);  check("p4_valid", 32'(out_valid), 32'h1);
                  check("p4_out",   32'(out_data),  32'h3C);

        // Async reset during STA T3, then read the target word back
        restart();
        load(4'd0, 8'h57); load(4'd1, 8'hE0); load(4'd2, 8'h4C); load(4'd3, 8'hF0);
        load(4'd12, 8'h99);
        en = 1'b1;
        tick(9);  check("p5_out_pre", 32'(out_data), 32'h07);
                  check("p5_pc_pre",  32'(pc),       32'h3);
        #2;
        rst = 1'b1;
        #1;
        check("p5_rst_pc",     32'(pc),       32'h0);
        check("p5_rst_out",    32'(out_data), 32'h0);
        check("p5_rst_halted", 32'(halted),   32'h0);
        en = 1'b0;
        rst = 1'b0;
        load(4'd0, 8'h1C); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
        en = 1'b1;
        tick(7);  check("p5_ram_valid", 32'(out_valid), 32'h1);
                  check("p5_ram_kept",  32'(out_data),  32'h99);
        en = 1'b0;

        // 12-bit data / 8-bit address: upper-half program and PC wrap
        wload(8'h00, 12'h680); wload(8'h80, 12'h55A); wload(8'h81, 12'hE00);
        wload(8'h82, 12'h6FF); wload(8'hFF, 12'h000);
        w_en = 1'b1;
        tick(9);  check("w_valid", 32'(w_valid), 32'h1);
                  check("w_out",   32'(w_out),   32'h05A);
        tick(3);  check("w_jmp_pc", 32'(w_pc),   32'hFF);
        tick(2);  check("w_wrap_pc", 32'(w_pc),  32'h00);
                  check("w_carry",   32'(w_carry), 32'h0);
                  check("w_halted",  32'(w_halted), 32'h0);
        w_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
